// File: rtl/gsim_pkg.sv
// Shared definitions for the banded-matrix multiplier gsim_amul:
// sizes, band coefficients, FSM states and shift-add / clamp helpers.
package gsim_pkg;

  // Default vector length (rows of the banded matrix A).
  localparam int N_DEF  = 16;
  // Data are signed 16.16; the accumulator carries 6 guard bits (sum |A| = 60).
  localparam int DATA_W = 32;
  localparam int ACC_W  = 38;

  // Band coefficients by distance from the diagonal.
  localparam int COEF_D0 = 20;
  localparam int COEF_D1 = -13;
  localparam int COEF_D2 = 6;
  localparam int COEF_D3 = -1;

  // 32-bit signed limits expressed in accumulator width.
  localparam logic signed [ACC_W-1:0] SAT_MAX = 38'sh00_7FFF_FFFF;
  localparam logic signed [ACC_W-1:0] SAT_MIN = 38'sh3F_8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EMIT = 2'd2
  } state_e;

  // Sign-extend a data word to accumulator width.
  function automatic logic signed [ACC_W-1:0] sext(input logic [DATA_W-1:0] x);
    return {{(ACC_W-DATA_W){x[DATA_W-1]}}, x};
  endfunction

  // 20x = 16x + 4x
  function automatic logic signed [ACC_W-1:0] mul20(input logic signed [ACC_W-1:0] a);
    return (a <<< 4) + (a <<< 2);
  endfunction

  // 13x = 8x + 4x + x
  function automatic logic signed [ACC_W-1:0] mul13(input logic signed [ACC_W-1:0] a);
    return (a <<< 3) + (a <<< 2) + a;
  endfunction

  // 6x = 4x + 2x
  function automatic logic signed [ACC_W-1:0] mul6(input logic signed [ACC_W-1:0] a);
    return (a <<< 2) + (a <<< 1);
  endfunction

  // Clamp an accumulator value into the signed 32-bit range.
  function automatic logic [DATA_W-1:0] sat32(input logic signed [ACC_W-1:0] a);
    logic [DATA_W-1:0] r;
    if (a > SAT_MAX) begin
      r = 32'h7FFF_FFFF;
    end else if (a < SAT_MIN) begin
      r = 32'h8000_0000;
    end else begin
      r = a[DATA_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/gsim_amul_row.sv
// gsim_amul_row: combinational 7-tap shift-add MAC for one row of A.
// taps_i[3] is the diagonal element x[i]; taps_i[k] is x[i+k-3] (zero
// when outside the vector). Macro GSIM_AMUL_SAT_EN selects clamping of
// the 38-bit result; otherwise the low 32 bits are returned (wrap).
module gsim_amul_row
  import gsim_pkg::*;
(
  input  logic [DATA_W-1:0] taps_i [7],
  output logic [DATA_W-1:0] b_o
);

  logic signed [ACC_W-1:0] acc;

  // Exact row sum: 20*x[i] - 13*(x[i-1]+x[i+1]) + 6*(x[i-2]+x[i+2]) - (x[i-3]+x[i+3]).
  always_comb begin
    acc = mul20(sext(taps_i[3]))
        - mul13(sext(taps_i[2])) - mul13(sext(taps_i[4]))
        + mul6(sext(taps_i[1]))  + mul6(sext(taps_i[5]))
        - sext(taps_i[0])        - sext(taps_i[6]);
`ifdef GSIM_AMUL_SAT_EN
    b_o = sat32(acc);
`else
    b_o = acc[DATA_W-1:0];
`endif
  end

endmodule

// File: rtl/gsim_amul.sv
// gsim_amul: streams in x[1..N] (signed 16.16), then streams out b = A*x
// for the fixed 7-band matrix A. One row MAC is time-shared across rows.
// b[1] is registered on the same edge that samples x[N], so out_valid
// rises one cycle after the last sample. Optional macro GSIM_AMUL_SAT_EN
// clamps results to the 32-bit signed range instead of wrapping.
module gsim_amul
  import gsim_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_en,
  input  logic [DATA_W-1:0] x_in,
  output logic              busy,
  output logic              out_valid,
  output logic [DATA_W-1:0] b_out
);

  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [DATA_W-1:0]  buf_q [N];
  logic [DATA_W-1:0]  buf_d [N];
  logic               busy_q;
  logic               valid_q;
  logic [DATA_W-1:0]  b_q;

  logic               load_en;
  int                 row_idx;
  int                 tap_idx;
  logic [DATA_W-1:0]  taps [7];
  logic [DATA_W-1:0]  row_b;

  // Samples are accepted only outside EMIT.
  assign load_en = in_en && (state_q != EMIT);

  // Next buffer contents: shift toward index 0 so buf[0] ends up holding x[1].
  always_comb begin
    buf_d = buf_q;
    if (load_en) begin
      for (int k = 0; k < N - 1; k++) begin
        buf_d[k] = buf_q[k + 1];
      end
      buf_d[N-1] = x_in;
    end else begin
      buf_d = buf_q;
    end
  end

  // Row window over the next-state buffer; row 0 is used on the final-sample edge.
  always_comb begin
    row_idx = (state_q == EMIT) ? int'(cnt_q) : 32'sd0;
    tap_idx = 32'sd0;
    for (int t = 0; t < 7; t++) begin
      tap_idx = row_idx + t - 3;
      if ((tap_idx >= 0) && (tap_idx < N)) begin
        taps[t] = buf_d[tap_idx[CNT_W-1:0]];
      end else begin
        taps[t] = '0;
      end
    end
  end

  gsim_amul_row u_row (
    .taps_i (taps),
    .b_o    (row_b)
  );

  // Control FSM, sample buffer and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      b_q     <= '0;
      for (int k = 0; k < N; k++) begin
        buf_q[k] <= '0;
      end
    end else begin
      buf_q <= buf_d;
      case (state_q)
        IDLE: begin
          valid_q <= 1'b0;
          b_q     <= '0;
          busy_q  <= 1'b0;
          if (in_en) begin
            state_q <= LOAD;
            cnt_q   <= CNT_W'(1);
          end
        end
        LOAD: begin
          valid_q <= 1'b0;
          b_q     <= '0;
          busy_q  <= 1'b0;
          if (in_en) begin
            if (cnt_q == CNT_W'(N - 1)) begin
              // Last sample: emit b[1] now, then rows 1..N-1.
              state_q <= EMIT;
              cnt_q   <= CNT_W'(1);
              valid_q <= 1'b1;
              b_q     <= row_b;
              busy_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        EMIT: begin
          valid_q <= 1'b1;
          b_q     <= row_b;
          if (cnt_q == CNT_W'(N - 1)) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q  <= cnt_q + CNT_W'(1);
            busy_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          b_q     <= '0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign out_valid = valid_q;
  assign b_out     = b_q;

endmodule

// File: tb/tb_gsim_amul.sv
// Self-checking bench for gsim_amul: directed frames plus random data,
// checked against a plain-arithmetic banded matrix-vector product.
module tb_gsim_amul;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_en;
  logic [31:0] x_in;
  logic        busy;
  logic        out_valid;
  logic [31:0] b_out;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gsim_amul #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_en     (in_en),
    .x_in      (x_in),
    .busy      (busy),
    .out_valid (out_valid),
    .b_out     (b_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: b[i] = sum_j A[i][j]*x[j] with A defined by |i-j|.
  function automatic logic [31:0] model_b(input logic [31:0] xs [N], input int i);
    longint acc;
    int     d;
    longint c;
    acc = 0;
    for (int j = 0; j < N; j++) begin
      d = (i > j) ? i - j : j - i;
      case (d)
        0: c = 20;
        1: c = -13;
        2: c = 6;
        3: c = -1;
        default: c = 0;
      endcase
      acc += c * longint'($signed(xs[j]));
    end
`ifdef GSIM_AMUL_SAT_EN
    if (acc > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (acc < -64'sd2147483648) return 32'h8000_0000;
`endif
    return acc[31:0];
  endfunction

  // Load a frame (optional random gaps), then check all N outputs.
  // pulses: drive 5 in_en pulses during EMIT. abort_at >= 0: reset after that output.
  task automatic run_frame(input string name, input logic [31:0] xs [N],
                           input int max_gap, input bit pulses, input int abort_at);
    logic [31:0] exp [N];
    int g;
    for (int i = 0; i < N; i++) exp[i] = model_b(xs, i);
    for (int j = 0; j < N; j++) begin
      in_en = 1'b1;
      x_in  = xs[j];
      @(posedge clk);
      #1;
      in_en = 1'b0;
      x_in  = 32'h0;
      if (j < N - 1) begin
        chk($sformatf("%s_load_valid_%0d", name, j), {31'b0, out_valid}, 32'd0);
        g = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
        repeat (g) begin
          @(posedge clk);
          #1;
        end
      end
    end
    chk($sformatf("%s_latency_valid", name), {31'b0, out_valid}, 32'd1);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      chk($sformatf("%s_valid_%0d", name, i + 1), {31'b0, out_valid}, 32'd1);
      chk($sformatf("%s_b_%0d", name, i + 1), b_out, exp[i]);
      chk($sformatf("%s_busy_%0d", name, i + 1), {31'b0, busy}, (i < N - 1) ? 32'd1 : 32'd0);
      if (i == abort_at) begin
        reset = 1'b0;
        #1;
        chk($sformatf("%s_abort_valid", name), {31'b0, out_valid}, 32'd0);
        chk($sformatf("%s_abort_b", name), b_out, 32'd0);
        chk($sformatf("%s_abort_busy", name), {31'b0, busy}, 32'd0);
        @(posedge clk);
        #1;
        chk($sformatf("%s_abort_hold", name), {31'b0, out_valid}, 32'd0);
        reset = 1'b1;
        return;
      end
      in_en = pulses && (i < 5);
      x_in  = in_en ? 32'h7FFF_0000 : 32'h0;
    end
    in_en = 1'b0;
    x_in  = 32'h0;
    @(negedge clk);
    chk($sformatf("%s_end_valid", name), {31'b0, out_valid}, 32'd0);
    chk($sformatf("%s_end_b", name), b_out, 32'd0);
    chk($sformatf("%s_end_busy", name), {31'b0, busy}, 32'd0);
  endtask

  logic [31:0] xs [N];
  logic [31:0] xr [N];

  initial begin
    reset = 1'b0;
    in_en = 1'b0;
    x_in  = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_busy",  {31'b0, busy}, 32'd0);
    chk("rst_b",     b_out, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Unit vector.
    for (int j = 0; j < N; j++) xs[j] = 32'h0;
    xs[0] = 32'h0001_0000;
    run_frame("unit", xs, 0, 1'b0, -1);

    // All ones.
    for (int j = 0; j < N; j++) xs[j] = 32'h0001_0000;
    run_frame("ones", xs, 0, 1'b0, -1);

    // Large alternating values: saturate or wrap.
    for (int j = 0; j < N; j++) xs[j] = (j % 2 == 0) ? 32'h4000_0000 : 32'hC000_0000;
    run_frame("sat", xs, 0, 1'b0, -1);

    // Random data back-to-back, then the same data with gaps.
    for (int j = 0; j < N; j++) xr[j] = $urandom;
    run_frame("rand", xr, 0, 1'b0, -1);
    run_frame("gap", xr, 3, 1'b0, -1);

    // Small random 16.16 values with in_en pulses during EMIT, then a clean frame.
    for (int j = 0; j < N; j++) xs[j] = {{12{1'b0}}, 20'($urandom)} - 32'h0008_0000;
    run_frame("pulse", xs, 0, 1'b1, -1);
    for (int j = 0; j < N; j++) xr[j] = $urandom;
    run_frame("after_pulse", xr, 1, 1'b0, -1);

    // Reset after b[7], then idle checks and a full new frame.
    run_frame("abort", xs, 0, 1'b0, 6);
    repeat (3) begin
      @(negedge clk);
      chk("post_abort_idle", {31'b0, out_valid}, 32'd0);
    end
    run_frame("post_abort", xr, 0, 1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gsim_amul.md
GSIM_AMUL -- requirements
Module: gsim_amul

Interface
REQ-001 SHALL have parameter N, default 16, meaning vector length (rows of the banded matrix A).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_en  input  1  x_in is valid this cycle.
REQ-005 SHALL have port x_in  input  32  signed 16.16 element x[j], sent in order j=1..N.
REQ-006 SHALL have port busy  output  1  high in EMIT; in_en is ignored while high.
REQ-007 SHALL have port out_valid  output  1  b_out is valid this cycle.
REQ-008 SHALL have port b_out  output  32  signed 16.16 element b[i], sent in order i=1..N.

Function
REQ-009 SHALL compute b = A*x, with A[i][i]=20, A[i][i±1]=-13, A[i][i±2]=6, A[i][i±3]=-1, and all other entries 0.
REQ-010 SHALL treat any x[j] with j<1 or j>N as zero, so edge rows use truncated taps.
REQ-011 SHALL implement the FSM with states IDLE, LOAD and EMIT.
REQ-012 SHALL take these transitions: IDLE->LOAD on the first in_en; LOAD->EMIT on the N-th sample; EMIT->IDLE after N outputs.
REQ-013 SHALL shift x_in into an N-entry buffer on each in_en cycle in IDLE or LOAD, and advance the sample counter (0..N-1).
REQ-014 SHALL allow in_en gaps in LOAD: the counter holds, with no timeout.
REQ-015 SHALL drive out_valid=1 on the cycle after the edge that samples x[N] (latency 1), and SHALL then emit b[1]..b[N] on N consecutive cycles with no stalls.
REQ-016 SHALL return out_valid to 0 after b[N] and return to IDLE; a new load may start on the next cycle.
REQ-017 SHALL drop in_en pulses during EMIT without affecting the buffer or the counter.
REQ-018 SHALL drive b_out to 0 whenever out_valid=0.
REQ-019 SHALL evaluate each row through a shift-add 7-tap MAC: 20x=(x<<4)+(x<<2); 13x=(x<<3)+(x<<2)+x; 6x=(x<<2)+(x<<1).
REQ-020 SHALL use a 38-bit signed accumulator (sum of |A[i][j]| is 60), which is exact and never wraps internally.
REQ-021 SHALL keep the output fractional point unchanged (16.16 in, 16.16 out); no rounding is needed because coefficients are integers.

Reset
REQ-022 SHALL, while reset=0, force state=IDLE, counter=0, every buffer entry=0, busy=0, out_valid=0 and b_out=0.
REQ-023 SHALL, on reset assertion mid-LOAD or mid-EMIT, abort immediately; no partial output follows release.
REQ-024 SHALL act on the first in_en after reset release as the x[1] sample.

Configuration
REQ-025 SHALL honour macro GSIM_AMUL_SAT_EN: when defined, a 38-bit result above 32'h7FFFFFFF outputs 32'h7FFFFFFF, and one below 32'h80000000 outputs 32'h80000000.
REQ-026 SHALL, with GSIM_AMUL_SAT_EN undefined, output the low 32 bits of the accumulator (wrap modulo 2^32).

Structure
REQ-027 SHALL place N, the coefficient constants (20, -13, 6, -1), the data and accumulator widths, and the state enum in shared package gsim_pkg.
REQ-028 SHALL use one sub-module, gsim_amul_row: a combinational 7-tap shift-add MAC with saturation, instantiated once and fed by a row-index window over the buffer.

Verification
REQ-029 SHALL cover the unit vector: x[1]=0x00010000, others 0 -> b[1..4]=0x00140000, 0xFFF30000, 0x00060000, 0xFFFF0000; b[5..16]=0.
REQ-030 SHALL cover all-ones: every x=0x00010000 -> b[1]=0x000C0000, b[2]=0xFFFF0000, b[3]=0x00050000, b[4..13]=0x00040000, b[14]=0x00050000, b[15]=0xFFFF0000, b[16]=0x000C0000.
REQ-031 SHALL cover saturation: x alternating 0x40000000/0xC0000000 -> interior b[i] = 0x7FFFFFFF for positive x[i] and 0x80000000 for negative x[i] with GSIM_AMUL_SAT_EN; without it, the wrapped low 32 bits.
REQ-032 SHALL cover gapped input: 16 samples with random 0-3 idle cycles between them -> results identical to back-to-back input, with out_valid exactly 1 cycle after the last sample.
REQ-033 SHALL cover in_en during EMIT: 5 extra pulses with x=0x7FFF0000 -> outputs unchanged, and the next frame is unaffected.
REQ-034 SHALL cover reset mid-EMIT after b[7]: out_valid=0 and b_out=0 at once; a full new frame afterwards is correct.
